// File: rtl/riscv_aes_pkg.sv
// Shared AES definitions for the RISC-V AES datapath: word geometry,
// serializer states and the 4x32 block type.
package riscv_aes_pkg;

  localparam int AES_WORD_W    = 32;
  localparam int AES_NUM_WORDS = 4;
  localparam int AES_IDX_W     = 3;

  typedef enum logic {
    IDLE,
    SEND
  } aes_ser_state_e;

  typedef logic [AES_NUM_WORDS-1:0][AES_WORD_W-1:0] aes_block_t;

endpackage

// File: rtl/riscv_aes_word_serializer.sv
// Captures one 128-bit AES block and streams it out as four indexed 32-bit
// words over valid/ready toward the core's register-write port.
module riscv_aes_word_serializer
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH = AES_WORD_W,
  parameter int NUM_WORDS  = AES_NUM_WORDS,
  parameter int ADDR_WIDTH = AES_IDX_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            test_en_i,
  input  logic                            flush_i,
  input  logic                            blk_valid_i,
  output logic                            blk_ready_o,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] blk_data_i,
  output logic                            word_valid_o,
  input  logic                            word_ready_i,
  output logic [DATA_WIDTH-1:0]           word_data_o,
  output logic [ADDR_WIDTH-1:0]           word_idx_o,
  output logic                            word_last_o,
  output logic                            busy_o
);

  localparam int SEL_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

  aes_ser_state_e                       state;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] buffer;
  logic [ADDR_WIDTH-1:0]                idx;
  logic [ADDR_WIDTH-1:0]                idx_next;
  logic                                 word_hs;

  assign idx_next     = idx + ADDR_WIDTH'(1);
  assign blk_ready_o  = (state == IDLE) & ~flush_i & ~test_en_i;
  assign word_valid_o = (state == SEND);
  assign busy_o       = (state == SEND);
  assign word_idx_o   = idx;
  assign word_last_o  = (state == SEND) && (idx == LAST_IDX);
  assign word_hs      = word_valid_o & word_ready_i;

  // idx returns to 0 whenever the FSM goes idle, so word_idx_o needs no
  // separate qualification; word_data_o is registered so it holds on stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buffer      <= '0;
      idx         <= '0;
      word_data_o <= '0;
    end else if (test_en_i) begin
      state       <= IDLE;
      buffer      <= '0;
      idx         <= '0;
      word_data_o <= '0;
    end else if (flush_i) begin
      state       <= IDLE;
      idx         <= '0;
      word_data_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (blk_valid_i && blk_ready_o) begin
            buffer      <= blk_data_i;
            idx         <= '0;
            word_data_o <= blk_data_i[DATA_WIDTH-1:0];
            state       <= SEND;
          end
        end
        SEND: begin
          if (word_hs) begin
            if (idx == LAST_IDX) begin
              state       <= IDLE;
              idx         <= '0;
              word_data_o <= '0;
            end else begin
              idx         <= idx_next;
              word_data_o <= buffer[idx_next[SEL_W-1:0]];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_aes_word_serializer.sv
// Directed scoreboard bench for the AES word serializer: expected words are
// queued when a block is offered and checked as each word is handshaked.
module tb_riscv_aes_word_serializer;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         test_en_i;
  logic         flush_i;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic [127:0] blk_data_i;
  logic         word_valid_o;
  logic         word_ready_i;
  logic [31:0]  word_data_o;
  logic [2:0]   word_idx_o;
  logic         word_last_o;
  logic         busy_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] BLK_A = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] BLK_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] BLK_C = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [127:0] BLK_D = 128'hD00D0003_D00D0002_D00D0001_D00D0000;
  localparam logic [127:0] BLK_F = {4{32'hFFFFFFFF}};

  riscv_aes_word_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .test_en_i    (test_en_i),
    .flush_i      (flush_i),
    .blk_valid_i  (blk_valid_i),
    .blk_ready_o  (blk_ready_o),
    .blk_data_i   (blk_data_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_idx_o   (word_idx_o),
    .word_last_o  (word_last_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [127:0] data,
                               input logic ready, input logic flush,
                               input logic testEn);
    @(posedge clk);
    #1;
    blk_valid_i  = valid;
    blk_data_i   = data;
    word_ready_i = ready;
    flush_i      = flush;
    test_en_i    = testEn;
  endtask

  task automatic pushBlock(input logic [127:0] data);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.idx  = 3'(k);
      e.data = data[k*32 +: 32];
      e.last = (k == 3);
      sb.push_back(e);
    end
  endtask

  task automatic waitDrained(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_queue_empty", 128'(sb.size()), 128'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 128'(word_valid_o), 128'd0);
    checkOutput({tag, "_data"},  128'(word_data_o),  128'd0);
    checkOutput({tag, "_idx"},   128'(word_idx_o),   128'd0);
    checkOutput({tag, "_last"},  128'(word_last_o),  128'd0);
    checkOutput({tag, "_busy"},  128'(busy_o),       128'd0);
  endtask

  // Scoreboard side: each word handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && !test_en_i && word_valid_o && word_ready_i) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("[TB] FAIL unexpected_word: observed idx %0d data %0h expected none",
               word_idx_o, word_data_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("word_data", 128'(word_data_o), 128'(e.data));
        checkOutput("word_idx",  128'(word_idx_o),  128'(e.idx));
        checkOutput("word_last", 128'(word_last_o), 128'(e.last));
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    test_en_i    = 1'b0;
    flush_i      = 1'b0;
    blk_valid_i  = 1'b0;
    blk_data_i   = '0;
    word_ready_i = 1'b0;

    @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_blk_ready", 128'(blk_ready_o), 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic serialization");
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_A);
    @(negedge clk);
    checkOutput("t1_ready_c0", 128'(blk_ready_o), 128'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t1_valid", 128'(word_valid_o), 128'd1);
      checkOutput("t1_last", 128'(word_last_o), 128'(k == 3));
      checkOutput("t1_ready_busy", 128'(blk_ready_o), 128'd0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_ready_c5", 128'(blk_ready_o), 128'd1);
    checkIdleOutputs("t1_idle_c5");
    checkOutput("t1_all_words", 128'(sb.size()), 128'd0);

    $display("[TB] stall on word 2");
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t2_hold_data", 128'(word_data_o), 128'h22222222);
      checkOutput("t2_hold_idx", 128'(word_idx_o), 128'd2);
      checkOutput("t2_hold_valid", 128'(word_valid_o), 128'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_last_at_c7", 128'(word_last_o), 128'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_done_c8", 128'(blk_ready_o), 128'd1);
    checkOutput("t2_all_words", 128'(sb.size()), 128'd0);

    $display("[TB] back-to-back blocks");
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_A);
    applyStimulus(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_B);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t3_ready_send", 128'(blk_ready_o), 128'd0);
      if (k < 3) applyStimulus(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_b_accept_ready", 128'(blk_ready_o), 128'd1);
    checkOutput("t3_gap_valid", 128'(word_valid_o), 128'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    waitDrained(20);

    $display("[TB] flush mid-block");
    applyStimulus(1'b1, BLK_C, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_C);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, BLK_D, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4_ready_in_flush", 128'(blk_ready_o), 128'd0);
    checkOutput("t4_words_left", 128'(sb.size()), 128'd2);
    sb.delete();
    applyStimulus(1'b1, BLK_D, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_D);
    @(negedge clk);
    checkIdleOutputs("t4_after_flush");
    checkOutput("t4_ready_after", 128'(blk_ready_o), 128'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    waitDrained(20);

    $display("[TB] test mode mid-block");
    applyStimulus(1'b1, BLK_C, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_C);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, BLK_F, 1'b0, 1'b0, 1'b1);
    sb.delete();
    @(negedge clk);
    checkOutput("t5_ready_first", 128'(blk_ready_o), 128'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, BLK_F, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkIdleOutputs("t5_test");
      checkOutput("t5_ready_test", 128'(blk_ready_o), 128'd0);
    end
    applyStimulus(1'b1, BLK_F, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_F);
    @(negedge clk);
    checkOutput("t5_ready_release", 128'(blk_ready_o), 128'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    waitDrained(20);

    $display("[TB] async reset during word 2");
    applyStimulus(1'b1, BLK_B, 1'b1, 1'b0, 1'b0);
    pushBlock(BLK_B);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t6_pre_reset_idx", 128'(word_idx_o), 128'd2);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("t6_async");
    checkOutput("t6_ready_async", 128'(blk_ready_o), 128'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t6_no_words", 128'(word_valid_o), 128'd0);
    end
    checkOutput("final_queue_empty", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
